// File: rtl/skewcode_pkg.sv
// Shared types and constants for the skew-code stepper.
package skewcode_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    STEP       = 2'd2,
    DONE       = 2'd3
  } skew_state_t;

  localparam int unsigned SKEW_WIDTH_DEF = 2;
  localparam int unsigned SKEW_POR_CODE  = 0;

endpackage

// File: rtl/skewcode_sync2.sv
// Two-flop synchronizer for the asynchronous in_mon copy of the skewed signal.
module skewcode_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/skewcode_stepper.sv
// Steps the skew brick select code one LSB at a time inside quiet windows of in_mon.
// Optional per-step wait timeout and forced flag: define SKEWCODE_STEPPER_TIMEOUT_EN.
module skewcode_stepper
  import skewcode_pkg::*;
#(
  parameter int unsigned WIDTH  = SKEW_WIDTH_DEF,
  parameter int unsigned SETTLE = 4
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             req,
  input  logic [WIDTH-1:0] target,
  input  logic             in_mon,
  output logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             ack
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  , output logic           forced
`endif
);

  localparam int unsigned QCNT_W = 8;

  skew_state_t       state_q, state_d;
  logic [WIDTH-1:0]  s_q, s_d, s_step;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              mon_s;
  logic              quiet_done;
  logic              timeout_hit;

`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              forced_q, forced_d;
`endif

  skewcode_sync2 u_sync (
    .clk   (CELCLK),
    .rst_n (CELRSTN),
    .d     (in_mon),
    .q     (mon_s)
  );

  assign quiet_done = (state_q == WAIT_QUIET) && !mon_s &&
                      (qcnt_q == QCNT_W'(SETTLE - 1));

`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  assign timeout_hit = (state_q == WAIT_QUIET) && (tcnt_q == TCNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // One LSB toward the latched target; saturates at both ends, never wraps.
  always_comb begin
    s_step = s_q;
    if ((s_q < tgt_q) && (s_q != '1)) begin
      s_step = s_q + WIDTH'(1);
    end else if ((s_q > tgt_q) && (s_q != '0)) begin
      s_step = s_q - WIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (target == s_q) ? DONE : WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (quiet_done || timeout_hit) begin
          state_d = STEP;
        end
      end
      STEP:    state_d = (s_step == tgt_q) ? DONE : WAIT_QUIET;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; counters clear on every entry to WAIT_QUIET.
  always_comb begin
    s_d    = s_q;
    tgt_d  = tgt_q;
    qcnt_d = qcnt_q;
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    forced_d = forced_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          tgt_d  = target;
          qcnt_d = '0;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
          tcnt_d   = '0;
          forced_d = 1'b0;
`endif
        end
      end
      WAIT_QUIET: begin
        qcnt_d = mon_s ? '0 : qcnt_q + QCNT_W'(1);
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (timeout_hit && !quiet_done) begin
          forced_d = 1'b1;
        end
`endif
      end
      STEP: begin
        s_d    = s_step;
        qcnt_d = '0;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
        tcnt_d = '0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      s_q    <= WIDTH'(SKEW_POR_CODE);
      tgt_q  <= '0;
      qcnt_q <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
      tcnt_q   <= '0;
      forced_q <= 1'b0;
`endif
    end else begin
      s_q    <= s_d;
      tgt_q  <= tgt_d;
      qcnt_q <= qcnt_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      forced_q <= forced_d;
`endif
    end
  end

  assign s    = s_q;
  assign busy = busy_q;
  assign ack  = ack_q;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  assign forced = forced_q;
`endif

endmodule

// File: tb/tb_skewcode_stepper.sv
// Directed bench for skewcode_stepper (SETTLE=4, TIMEOUT=64).
module tb_skewcode_stepper;

  localparam int unsigned W = 2;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         req    = 1'b0;
  logic         in_mon = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] s;
  logic         busy;
  logic         ack;
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
  logic         forced;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] tgt;
    int           ack_cyc;
    logic [W-1:0] exp_s;
  } vec_t;

  vec_t vecs[7];
  int   exp_up[16];

  always #5 clk = ~clk;

  skewcode_stepper #(.WIDTH(W), .SETTLE(4)) dut (
    .CELCLK  (clk),
    .CELRSTN (rst_n),
    .req     (req),
    .target  (target),
    .in_mon  (in_mon),
    .s       (s),
    .busy    (busy),
    .ack     (ack)
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
    , .forced (forced)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue a request with in_mon quiet and wait for ack; cycle 1 follows the sampling edge.
  task automatic run_move(input logic [W-1:0] tgt, input int exp_cyc,
                          input logic [W-1:0] exp_s, input string tag);
    int cyc;
    bit seen;
    bit busy_ok;
    target = tgt;
    req    = 1'b1;
    tick();
    req     = 1'b0;
    cyc     = 1;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc < 200) begin
      if (ack) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        tick();
        cyc++;
      end
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    chk({tag, "_ack_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_s"}, 32'(s), 32'(exp_s));
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    tick();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bit  mono;
    logic [W-1:0] prev;

    vecs[0] = '{tgt: 2'd3, ack_cyc: 1,  exp_s: 2'd3};
    vecs[1] = '{tgt: 2'd0, ack_cyc: 16, exp_s: 2'd0};
    vecs[2] = '{tgt: 2'd2, ack_cyc: 11, exp_s: 2'd2};
    vecs[3] = '{tgt: 2'd1, ack_cyc: 6,  exp_s: 2'd1};
    vecs[4] = '{tgt: 2'd3, ack_cyc: 11, exp_s: 2'd3};
    vecs[5] = '{tgt: 2'd2, ack_cyc: 6,  exp_s: 2'd2};
    vecs[6] = '{tgt: 2'd0, ack_cyc: 11, exp_s: 2'd0};
    exp_up  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    // Reset values
    #12;
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
    chk("rst_forced", 32'(forced), 32'd0);
`endif
    #10 rst_n = 1'b1;
    tick();
    tick();

    // Equal target: ack in cycle 1, busy low in cycle 2
    target = 2'd0;
    req    = 1'b1;
    tick();
    req = 1'b0;
    chk("eq_ack_c1", 32'(ack), 32'd1);
    chk("eq_busy_c1", 32'(busy), 32'd1);
    chk("eq_s_c1", 32'(s), 32'd0);
    tick();
    chk("eq_busy_c2", 32'(busy), 32'd0);
    chk("eq_ack_c2", 32'(ack), 32'd0);

    // Upward move 0->3, per-cycle expectations
    target = 2'd3;
    req    = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("up_s_c%0d", c), 32'(s), 32'(exp_up[c-1]));
      chk($sformatf("up_ack_c%0d", c), 32'(ack), (c == 16) ? 32'd1 : 32'd0);
      chk($sformatf("up_busy_c%0d", c), 32'(busy), 32'd1);
      tick();
    end
    chk("up_busy_c17", 32'(busy), 32'd0);

    // Table of moves from s=3
    for (int i = 0; i < 7; i++) begin
      run_move(vecs[i].tgt, vecs[i].ack_cyc, vecs[i].exp_s, $sformatf("vec%0d", i));
    end

    // Quiet-window interruption: mon_s high in cycle 3 restarts the count
    target = 2'd1;
    req    = 1'b1;
    tick();
    req    = 1'b0;
    in_mon = 1'b1;
    tick();
    in_mon = 1'b0;
    for (int c = 2; c < 8; c++) tick();
    chk("intr_s_c8", 32'(s), 32'd0);
    chk("intr_busy_c8", 32'(busy), 32'd1);
    tick();
    chk("intr_s_c9", 32'(s), 32'd1);
    chk("intr_ack_c9", 32'(ack), 32'd1);
    tick();

    // Downward move 3->0 with an ignored request while busy
    run_move(2'd3, 11, 2'd3, "pre_down");
    target = 2'd0;
    req    = 1'b1;
    tick();
    req  = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    mono = 1'b1;
    prev = s;
    while (!seen && cyc < 200) begin
      if (ack) begin
        seen = 1'b1;
      end else begin
        if (cyc == 3) begin
          target = 2'd2;
          req    = 1'b1;
        end else begin
          req = 1'b0;
        end
        tick();
        cyc++;
        if (s > prev) mono = 1'b0;
        prev = s;
      end
    end
    req = 1'b0;
    chk("down_ack_seen", 32'(seen), 32'd1);
    chk("down_ack_cycle", 32'(cyc), 32'd16);
    chk("down_s", 32'(s), 32'd0);
    chk("down_monotonic", 32'(mono), 32'd1);
    for (int c = 0; c < 8; c++) tick();
    chk("down_ignored_busy", 32'(busy), 32'd0);
    chk("down_ignored_s", 32'(s), 32'd0);

    // Asynchronous reset in the middle of a move at s=2
    target = 2'd3;
    req    = 1'b1;
    tick();
    req = 1'b0;
    cyc = 1;
    while (s != 2'd2 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("mid_reach_s2", 32'(s), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack || busy || s != 2'd0) seen = 1'b1;
    end
    chk("mid_rst_discarded", 32'(seen), 32'd0);

`ifdef SKEWCODE_STEPPER_TIMEOUT_EN
    // Timeout with in_mon toggling every cycle
    chk("to_forced_pre", 32'(forced), 32'd0);
    target = 2'd1;
    req    = 1'b1;
    tick();
    req  = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      in_mon = ~in_mon;
      if (ack) begin
        seen = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    in_mon = 1'b0;
    chk("to_ack_seen", 32'(seen), 32'd1);
    chk("to_ack_cycle", 32'(cyc), 32'd66);
    chk("to_s", 32'(s), 32'd1);
    chk("to_forced", 32'(forced), 32'd1);
    tick();
    tick();
    tick();
    target = 2'd1;
    req    = 1'b1;
    tick();
    req = 1'b0;
    chk("to_forced_clear", 32'(forced), 32'd0);
    chk("to_clear_ack", 32'(ack), 32'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
